// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state encoding and edge-select constants for the capture sequencer
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic EDGE_FALL = 1'b0;
    localparam logic EDGE_RISE = 1'b1;

endpackage

// File: rtl/capture_ctrl_if.sv
// rtl/capture_ctrl_if.sv - FIFO-side port bundle between the capture sequencer and the sample FIFO
interface capture_ctrl_if #(
    parameter int DATA_SIZE = 12
) ();

    logic                 fifo_w_inc_o;
    logic [DATA_SIZE-1:0] fifo_w_data_o;
    logic                 fifo_r_inc_o;
    logic                 fifo_empty_i;

    modport master (
        output fifo_w_inc_o,
        output fifo_w_data_o,
        output fifo_r_inc_o,
        input  fifo_empty_i
    );

    modport slave (
        input  fifo_w_inc_o,
        input  fifo_w_data_o,
        input  fifo_r_inc_o,
        output fifo_empty_i
    );

endinterface

// File: rtl/trig_detect.sv
// rtl/trig_detect.sv - level/edge trigger detector holding the previous accepted sample
module trig_detect
    import capture_pkg::*;
#(
    parameter int DATA_SIZE = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 update_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    input  logic [DATA_SIZE-1:0] level_i,
    input  logic                 rising_i,
    output logic                 trig_o
);

    logic [DATA_SIZE-1:0] prev_q, prev_d;
    logic                 prev_valid_q, prev_valid_d;
    logic                 hit_rise, hit_fall;

    // Next-state for the previous-sample history; idle forgets it so a fresh capture never edges against stale data
    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (clear_i) begin
            prev_valid_d = 1'b0;
        end else if (update_i) begin
            prev_d       = sample_i;
            prev_valid_d = 1'b1;
        end
    end

    // Strict inequality on the previous side keeps a sample held at the level from re-firing
    always_comb begin
        hit_rise = (prev_q < level_i) && (sample_i >= level_i);
        hit_fall = (prev_q > level_i) && (sample_i <= level_i);
        trig_o   = update_i && prev_valid_q && ((rising_i == EDGE_RISE) ? hit_rise : hit_fall);
    end

    // History registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - oscilloscope capture sequencer (optional auto-trigger: CAPTURE_AUTO_TRIG_EN)
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DATA_SIZE    = 12,
    parameter int ADDR_SIZE    = 8,
    parameter int TIMEOUT_SIZE = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    arm_i,
    input  logic                    abort_i,
    input  logic [DATA_SIZE-1:0]    sample_i,
    input  logic                    sample_valid_i,
    input  logic [DATA_SIZE-1:0]    trig_level_i,
    input  logic                    trig_rising_i,
    input  logic [ADDR_SIZE-1:0]    pre_len_i,
    input  logic [ADDR_SIZE-1:0]    post_len_i,
    input  logic                    rd_req_i,
`ifdef CAPTURE_AUTO_TRIG_EN
    input  logic [TIMEOUT_SIZE-1:0] auto_timeout_i,
`endif
    capture_ctrl_if.master          fifo,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    triggered_o,
    output logic                    trig_forced_o
);

    localparam int CW = ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE-1:0] MAX_LEN = '1;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] pre_q, pre_d;
    logic [ADDR_SIZE-1:0] post_q, post_d;
    logic [ADDR_SIZE-1:0] post_cnt_q, post_cnt_d;
    logic                 w_inc_q, w_inc_d;
    logic [DATA_SIZE-1:0] w_data_q, w_data_d;
    logic                 drop_q, drop_d;
    logic                 triggered_q, triggered_d;

    logic                 in_capture, in_idle, take, trig_hit, force_trig, rd_fire;
    logic [CW-1:0]        cnt_inc, len_sum;
    logic [ADDR_SIZE-1:0] post_next, post_clamped;

    assign in_idle    = (state_q == IDLE);
    assign in_capture = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
    assign take       = sample_valid_i && in_capture && !abort_i;
    assign cnt_inc    = cnt_q + CW'(1);
    assign post_next  = post_cnt_q + ADDR_SIZE'(1);
    assign rd_fire    = (state_q == DONE) && rd_req_i && !fifo.fifo_empty_i && (cnt_q != '0);

    // Total window must leave one slot free, so post shrinks to fit behind pre
    assign len_sum      = {1'b0, pre_len_i} + {1'b0, post_len_i};
    assign post_clamped = (len_sum > {1'b0, MAX_LEN}) ? (MAX_LEN - pre_len_i) : post_len_i;

    trig_detect #(
        .DATA_SIZE(DATA_SIZE)
    ) u_trig_detect (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (in_idle),
        .update_i (take),
        .sample_i (sample_i),
        .level_i  (trig_level_i),
        .rising_i (trig_rising_i),
        .trig_o   (trig_hit)
    );

`ifdef CAPTURE_AUTO_TRIG_EN
    logic [TIMEOUT_SIZE-1:0] to_cnt_q, to_cnt_d;
    logic                    forced_q, forced_d;

    assign force_trig = take && (state_q == ARMED) && (auto_timeout_i != '0) &&
                        (to_cnt_q >= auto_timeout_i);
`else
    assign force_trig = 1'b0;
`endif

    // Sequencer: window fill, sliding window, post count, host drain
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        post_d      = post_q;
        post_cnt_d  = post_cnt_q;
        w_inc_d     = 1'b0;
        w_data_d    = w_data_q;
        drop_d      = 1'b0;
        triggered_d = triggered_q;
`ifdef CAPTURE_AUTO_TRIG_EN
        to_cnt_d    = to_cnt_q;
        forced_d    = forced_q;
`endif
        case (state_q)
            IDLE: begin
                if (arm_i && !abort_i) begin
                    pre_d       = pre_len_i;
                    post_d      = post_clamped;
                    post_cnt_d  = '0;
                    triggered_d = 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
                    to_cnt_d    = '0;
                    forced_d    = 1'b0;
`endif
                    state_d     = (pre_len_i == '0) ? ARMED : PRE;
                end
            end
            PRE: begin
                if (take) begin
                    w_inc_d  = 1'b1;
                    w_data_d = sample_i;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == {1'b0, pre_q}) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (take) begin
                    if (trig_hit || force_trig) begin
                        w_inc_d     = 1'b1;
                        w_data_d    = sample_i;
                        cnt_d       = cnt_inc;
                        triggered_d = 1'b1;
`ifdef CAPTURE_AUTO_TRIG_EN
                        if (!trig_hit) begin
                            forced_d = 1'b1;
                        end
`endif
                        post_cnt_d  = ADDR_SIZE'(1);
                        state_d     = (post_q <= ADDR_SIZE'(1)) ? DONE : POST;
                    end else begin
`ifdef CAPTURE_AUTO_TRIG_EN
                        if (to_cnt_q != '1) begin
                            to_cnt_d = to_cnt_q + TIMEOUT_SIZE'(1);
                        end
`endif
                        // An empty pre-window keeps nothing, so untriggered samples are not stored
                        if (pre_q != '0) begin
                            w_inc_d  = 1'b1;
                            w_data_d = sample_i;
                            if (cnt_q == {1'b0, pre_q}) begin
                                drop_d = 1'b1;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                    end
                end
            end
            POST: begin
                if (take) begin
                    w_inc_d    = 1'b1;
                    w_data_d   = sample_i;
                    cnt_d      = cnt_inc;
                    post_cnt_d = post_next;
                    if (post_next == post_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (rd_fire) begin
                    cnt_d = cnt_q - CW'(1);
                end
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort wins over everything; the controller forgets its occupancy and the host drains the FIFO
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            post_cnt_q  <= '0;
            w_inc_q     <= 1'b0;
            w_data_q    <= '0;
            drop_q      <= 1'b0;
            triggered_q <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
            to_cnt_q    <= '0;
            forced_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            post_cnt_q  <= post_cnt_d;
            w_inc_q     <= w_inc_d;
            w_data_q    <= w_data_d;
            drop_q      <= drop_d;
            triggered_q <= triggered_d;
`ifdef CAPTURE_AUTO_TRIG_EN
            to_cnt_q    <= to_cnt_d;
            forced_q    <= forced_d;
`endif
        end
    end

    assign fifo.fifo_w_inc_o  = w_inc_q;
    assign fifo.fifo_w_data_o = w_data_q;
    assign fifo.fifo_r_inc_o  = drop_q | rd_fire;
    assign busy_o             = !in_idle;
    assign done_o             = (state_q == DONE);
    assign triggered_o        = triggered_q;
`ifdef CAPTURE_AUTO_TRIG_EN
    assign trig_forced_o      = forced_q;
`else
    assign trig_forced_o      = 1'b0;
`endif

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - self-checking bench for capture_ctrl with a behavioural FIFO and readout scoreboard
module tb_capture_ctrl;
    import capture_pkg::*;

    localparam int DW = 12;
    localparam int AW = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst, arm, abort, sval, rising, rd_req;
    logic [DW-1:0] smp, level;
    logic [AW-1:0] pre_len, post_len;
    logic          busy, done, trig, forced;
`ifdef CAPTURE_AUTO_TRIG_EN
    logic [TW-1:0] auto_to;
`endif

    capture_ctrl_if #(.DATA_SIZE(DW)) fif ();

    capture_ctrl #(
        .DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT_SIZE(TW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .arm_i          (arm),
        .abort_i        (abort),
        .sample_i       (smp),
        .sample_valid_i (sval),
        .trig_level_i   (level),
        .trig_rising_i  (rising),
        .pre_len_i      (pre_len),
        .post_len_i     (post_len),
        .rd_req_i       (rd_req),
`ifdef CAPTURE_AUTO_TRIG_EN
        .auto_timeout_i (auto_to),
`endif
        .fifo           (fif),
        .busy_o         (busy),
        .done_o         (done),
        .triggered_o    (trig),
        .trig_forced_o  (forced)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO plus event counters
    logic [DW-1:0] fifo_q[$];
    int            out_q[$];
    logic          fifo_empty = 1'b1;
    logic          flush = 1'b0;
    int            drop_cnt = 0, wr_cnt = 0, coinc_err = 0, ovf_err = 0;
    logic [DW-1:0] word;

    assign fif.fifo_empty_i = fifo_empty;

    always @(posedge clk) begin
        if (flush) begin
            fifo_q.delete();
        end else begin
            if (fif.fifo_r_inc_o) begin
                if (!done) begin
                    drop_cnt++;
                    if (!fif.fifo_w_inc_o) coinc_err++;
                end
                if (fifo_q.size() > 0) begin
                    word = fifo_q.pop_front();
                    if (done) out_q.push_back(int'(word));
                end else begin
                    ovf_err++;
                end
            end
            if (fif.fifo_w_inc_o) begin
                wr_cnt++;
                fifo_q.push_back(fif.fifo_w_data_o);
                if (fifo_q.size() > 16) ovf_err++;
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sample-level reference model of the capture window
    int stim_q[$];
    int ref_q[$];
    int exp_q[$];
    int exp_done, exp_trig, exp_forced;
    int cur_pre, cur_post, cur_lvl, cur_auto;
    bit cur_rise;

    task automatic build_expected();
        int words[$];
        int st, p, posts, eff_post, to, s;
        bit pv, hit, frc;
        exp_trig = 0; exp_forced = 0;
        eff_post = (cur_pre + cur_post > 15) ? 15 - cur_pre : cur_post;
        st = (cur_pre == 0) ? 1 : 0;
        pv = 0; p = 0; to = 0; posts = 0;
        foreach (ref_q[i]) begin
            s = ref_q[i];
            if (st == 0) begin
                words.push_back(s);
                if (words.size() == cur_pre) st = 1;
            end else if (st == 1) begin
                hit = pv && (cur_rise ? (p < cur_lvl && s >= cur_lvl) : (p > cur_lvl && s <= cur_lvl));
                frc = !hit && cur_auto != 0 && to >= cur_auto;
                if (hit || frc) begin
                    words.push_back(s);
                    exp_trig = 1; exp_forced = int'(frc); posts = 1;
                    st = (eff_post <= 1) ? 3 : 2;
                end else begin
                    to++;
                    if (cur_pre > 0) begin
                        words.push_back(s);
                        void'(words.pop_front());
                    end
                end
            end else if (st == 2) begin
                words.push_back(s);
                posts++;
                if (posts == eff_post) st = 3;
            end
            if (st == 3) break;
            p = s; pv = 1;
        end
        exp_done = int'(st == 3);
        exp_q = words;
    endtask

    task automatic do_arm(input int pre, input int post, input bit rise, input int lvl);
        cur_pre = pre; cur_post = post; cur_rise = rise; cur_lvl = lvl;
        pre_len = AW'(pre); post_len = AW'(post); rising = rise; level = DW'(lvl);
        ref_q.delete();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic drive_samples(input bit gap);
        foreach (stim_q[i]) begin
            smp  = DW'(stim_q[i]);
            sval = 1'b1;
            ref_q.push_back(stim_q[i]);
            @(negedge clk);
            sval = 1'b0;
            if (gap) @(negedge clk);
        end
        stim_q.delete();
    endtask

    task automatic flush_fifo();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic check_capture(input string tag, output int base);
        int waited, n;
        build_expected();
        @(negedge clk);
        check({tag, "_done"}, int'(done), exp_done);
        check({tag, "_triggered"}, int'(trig), exp_trig);
        check({tag, "_forced"}, int'(forced), exp_forced);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check({tag, "_arm_in_done_ignored"}, int'(done), exp_done);
        base = out_q.size();
        rd_req = 1'b1;
        waited = 0;
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        rd_req = 1'b0;
        check({tag, "_drain_in_time"}, int'(waited < 200), 1);
        n = out_q.size() - base;
        check({tag, "_word_count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s_word%0d", tag, i), out_q[base + i], exp_q[i] & 'hFFF);
        check({tag, "_fifo_empty_after"}, fifo_q.size(), 0);
        check({tag, "_idle_after"}, int'(busy), 0);
    endtask

    typedef struct {
        int pre; int post; bit rise; int lvl; int start; int step; int n; bit gap;
        int exp_n; int exp_first; int exp_last;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, c0, w0, base, n;
        vecs[0] = '{4, 8, 1, 100, 0, 10, 20, 0, 12, 60, 170};
        vecs[1] = '{10, 10, 1, 100, 0, 10, 20, 1, 15, 0, 140};
        vecs[2] = '{2, 4, 0, 100, 150, -25, 7, 0, 6, 150, 25};
        vecs[3] = '{0, 3, 1, 50, 0, 20, 8, 0, 3, 60, 100};
        vecs[4] = '{3, 0, 1, 100, 0, 30, 8, 0, 4, 30, 120};
        vecs[5] = '{2, 1, 1, 35, 5, 10, 8, 1, 3, 15, 35};
        vecs[6] = '{15, 8, 1, 100, 0, 5, 25, 0, 16, 25, 100};

        rst = 1'b1; arm = 0; abort = 0; sval = 0; rising = 1; rd_req = 0;
        smp = '0; level = '0; pre_len = '0; post_len = '0;
        cur_auto = 0;
`ifdef CAPTURE_AUTO_TRIG_EN
        auto_to = '0;
`endif
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_triggered", int'(trig), 0);
        check("reset_forced", int'(forced), 0);
        check("reset_w_inc", int'(fif.fifo_w_inc_o), 0);
        check("reset_r_inc", int'(fif.fifo_r_inc_o), 0);
        rst = 1'b0;
        @(negedge clk);

        // Constant input below level: window slides, no trigger
        d0 = drop_cnt; c0 = coinc_err; w0 = wr_cnt;
        do_arm(4, 8, 1, 100);
        for (int i = 0; i < 20; i++) stim_q.push_back(50);
        drive_samples(0);
        @(negedge clk);
        check("hold_busy", int'(busy), 1);
        check("hold_done", int'(done), 0);
        check("hold_triggered", int'(trig), 0);
        check("hold_drops", drop_cnt - d0, 16);
        check("hold_drop_with_write", coinc_err - c0, 0);
        check("hold_writes", wr_cnt - w0, 20);
        check("hold_fifo_words", fifo_q.size(), 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("hold_abort_idle", int'(busy), 0);
        flush_fifo();

        // Falling edge: holding at the level does not fire; the real crossing does
        do_arm(1, 2, 0, 100);
        stim_q = '{100, 100, 100, 100};
        drive_samples(0);
        check("fall_hold_no_trig", int'(trig), 0);
        stim_q = '{150, 120, 100, 100};
        drive_samples(0);
        check_capture("fall", base);

        // Abort mid-post after three post writes
        do_arm(4, 8, 1, 100);
        for (int i = 0; i <= 12; i++) stim_q.push_back(i * 10);
        drive_samples(0);
        check("abort_pre_busy", int'(busy), 1);
        check("abort_pre_triggered", int'(trig), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        flush_fifo();

        // Table-driven captures
        foreach (vecs[v]) begin
            do_arm(vecs[v].pre, vecs[v].post, vecs[v].rise, vecs[v].lvl);
            for (int i = 0; i < vecs[v].n; i++) stim_q.push_back(vecs[v].start + i * vecs[v].step);
            drive_samples(vecs[v].gap);
            check_capture($sformatf("vec%0d", v), base);
            n = out_q.size() - base;
            check($sformatf("vec%0d_table_count", v), n, vecs[v].exp_n);
            if (n > 0) begin
                check($sformatf("vec%0d_table_first", v), out_q[base], vecs[v].exp_first);
                check($sformatf("vec%0d_table_last", v), out_q[out_q.size() - 1], vecs[v].exp_last);
            end
        end

        // Reset mid-capture abandons it
        do_arm(4, 8, 1, 100);
        stim_q = '{10, 20};
        drive_samples(0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_busy", int'(busy), 0);
        check("midreset_triggered", int'(trig), 0);
        flush_fifo();

`ifdef CAPTURE_AUTO_TRIG_EN
        auto_to = TW'(6);
        cur_auto = 6;
        do_arm(4, 8, 1, 100);
        for (int i = 0; i < 20; i++) stim_q.push_back(50);
        drive_samples(0);
        check_capture("auto", base);
        check("auto_forced_sticky", int'(forced), 1);
        auto_to = '0;
        cur_auto = 0;
`endif

        check("fifo_model_overflow", ovf_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Single-clock sequencer for the oscilloscope sample FIFO.
- Owns the FIFO write side and, during capture, the read side. Keeps a sliding pre-trigger window, detects a level/edge trigger on ADC samples, records a fixed post-trigger count, then hands the read port to the host readout.
- The FIFO is instantiated with write and read clocks tied to clk_i.

Parameters:
- DATA_SIZE, 12, ADC sample width.
- ADDR_SIZE, 8, FIFO address width; depth D = 2^ADDR_SIZE.
- TIMEOUT_SIZE, 16, auto-trigger timeout counter width (optional feature only).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- arm_i  in  1  1-cycle pulse; starts a capture from IDLE
- abort_i  in  1  1-cycle pulse; returns to IDLE from any state
- sample_i  in  DATA_SIZE  ADC sample
- sample_valid_i  in  1  sample_i valid this cycle
- trig_level_i  in  DATA_SIZE  trigger threshold, unsigned
- trig_rising_i  in  1  1 = rising edge, 0 = falling edge
- pre_len_i  in  ADDR_SIZE  pre-trigger samples kept
- post_len_i  in  ADDR_SIZE  post-trigger samples recorded
- rd_req_i  in  1  host read request (honoured in DONE only)
- fifo_empty_i  in  1  FIFO r_empty_o
- fifo_w_inc_o  out  1  FIFO write increment
- fifo_w_data_o  out  DATA_SIZE  FIFO write data
- fifo_r_inc_o  out  1  FIFO read increment
- busy_o  out  1  state != IDLE
- done_o  out  1  state == DONE
- triggered_o  out  1  trigger seen in the current capture
- trig_forced_o  out  1  trigger was forced (optional feature)

Behaviour:
- Reset: state = IDLE; all outputs 0; occupancy cnt = 0; prev_valid = 0. Reset mid-capture abandons it. FIFO contents are not flushed by this block.
- States: IDLE, PRE, ARMED, POST, DONE.
- Write path: on sample_valid_i in PRE/ARMED/POST, register sample_i into fifo_w_data_o and pulse fifo_w_inc_o for 1 cycle. Latency is 1 clock.
- Occupancy: cnt is a registered count of words in the FIFO, sized to hold values 0..D.
  - cnt tracks the controller's own w_inc/r_inc.
  - Write and drop in the same cycle leave cnt unchanged.
  - FIFO full/empty flags are not used for window control.
- Length clamp: effective pre = pre_len_i, post = post_len_i, both latched at arm. If pre + post > D-1, post is clamped to D-1-pre.
- IDLE:
  - arm_i -> PRE; clears triggered_o and trig_forced_o.
  - If pre = 0, go straight to ARMED.
- PRE: write each valid sample. When cnt reaches pre (counting this write) -> ARMED. Trigger is ignored in PRE.
- ARMED:
  - Write each valid sample.
  - If cnt == pre at that write, also pulse fifo_r_inc_o in the same cycle to drop the oldest word, so the window slides.
  - Trigger condition on a valid sample with prev_valid = 1:
    - rising: prev < level and sample >= level;
    - falling: prev > level and sample <= level.
  - On trigger: the trigger sample is written as the first post sample, triggered_o = 1, -> POST.
  - If post = 0: the trigger sample is still written, then -> DONE.
- POST: write valid samples with no drops. After post writes, including the trigger sample -> DONE.
- DONE:
  - fifo_r_inc_o = rd_req_i & ~fifo_empty_i, with cnt decremented on each read.
  - New samples are ignored.
  - When cnt == 0 -> IDLE.
- prev register: updates on every sample_valid_i in PRE/ARMED/POST. prev_valid clears in IDLE.
- Priority: abort_i > trigger > arm_i. abort_i forces IDLE; outstanding FIFO words remain and the host must drain them. arm_i outside IDLE is ignored.
- Equal-level hold (sample == level for consecutive samples) does not retrigger.

Optional Feature:
- Macro: CAPTURE_AUTO_TRIG_EN.
- Defined:
  - Adds input auto_timeout_i [TIMEOUT_SIZE].
  - A counter runs on valid samples in ARMED. When it reaches auto_timeout_i with no trigger, a trigger is forced on the next valid sample and trig_forced_o = 1 (sticky until next arm).
  - auto_timeout_i = 0 disables the forced trigger.
- Undefined: no port, no counter, trig_forced_o tied to 0.

Decomposition:
- Package capture_pkg:
  - state enum (IDLE, PRE, ARMED, POST, DONE);
  - edge-select constants EDGE_FALL = 0, EDGE_RISE = 1.
- Sub-module trig_detect: holds prev and prev_valid; compares sample against level with edge select; outputs a 1-cycle trig pulse aligned to sample_valid_i.

Test Plan (ADDR_SIZE=4, D=16, pre=4, post=8, rising, level=100):
- Ramp 0,10,20,... after arm -> trigger at sample 100; FIFO readout = 60,70,80,90,100..170 (12 words); done_o high; IDLE after the last read.
- 20 samples of 50 while ARMED -> cnt stays 4, exactly 16 drop pulses, fifo_r_inc_o coincides with w_inc; no trigger.
- Falling edge, level=100, samples 150,120,100 -> trigger on 100; holding at 100 does not retrigger.
- pre=10, post=10 -> post clamped to 5; 15 words read out.
- abort_i during POST after 3 post writes -> IDLE next cycle, busy_o = 0; arm_i in DONE is ignored.
- CAPTURE_AUTO_TRIG_EN, auto_timeout_i=6, constant 50 -> forced trigger on the 7th ARMED sample; trig_forced_o = 1 and triggered_o = 1.
